uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with a TX FIFO. Configurable data width, parity and stop bits.
//   Paced by the shared Baud_rate tick (one pulse per bit period, same tick as uart_rx).
//   Replaces the single-byte uart_tx where the host writes byte bursts without waiting on busy.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, 5..9, sent LSB first
//   PARITY      0   0 = none, 1 = odd, 2 = even
//   STOP_BITS   1   stop bits per frame, 1 or 2
//   FIFO_DEPTH  4   FIFO entries; power of 2, >= 2
// PORTS
//   clk        in   1                      system clock; all logic on posedge
//   rst        in   1                      synchronous reset, active-high
//   tick       in   1                      one-clk pulse per bit period, from Baud_rate
//   data_in    in   DATA_BITS              byte to enqueue
//   send       in   1                      enqueue strobe; data_in is captured when send && !full
//   full       out  1                      FIFO holds FIFO_DEPTH entries
//   overflow   out  1                      one-clk pulse: send while full; the byte is dropped
//   fifo_count out  $clog2(FIFO_DEPTH)+1   entries currently queued (excludes the frame in flight)
//   busy       out  1                      high when state != IDLE
//   tx         out  1                      serial line, registered, idles high
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge) puts these values on the next edge:
//     tx=1, busy=0, full=0, overflow=0, fifo_count=0, state=IDLE.
//     FIFO pointers are cleared and the frame in flight is aborted.
//     rst has priority over send and tick.
//   FIFO
//     push = send && !full, evaluated on pre-edge state.
//     A push and pop in the same cycle leave count unchanged. A push while full is rejected, even if a pop occurs that cycle.
//     Pointers wrap modulo FIFO_DEPTH.
//     full = (count == FIFO_DEPTH); empty = (count == 0).
//   FSM: IDLE, START, DATA, PARITY, STOP. State advances only on edges where tick=1.
//     Between ticks, state, tx and the counters hold.
//     IDLE: tx=1. On tick with !empty: pop head into shift reg and go to START. The FSM samples the FIFO only on a tick.
//     START: tx=0 for one bit period. On tick: go to DATA with bit_idx=0.
//     DATA: tx=shift[0]. On tick: shift right and bit_idx++.
//       After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
//     PARITY: tx = ^data (even) or ~^data (odd), computed over the DATA_BITS captured at pop. On tick: go to STOP.
//     STOP: tx=1 for STOP_BITS bit periods. On the final stop tick:
//       if !empty, pop and go straight to START (back-to-back, no idle bit); else go to IDLE.
//   Timing
//     tx is updated on the same edge as the state transition; there is no extra pipeline stage.
//     Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
//     Start-bit latency: a byte pushed into an empty FIFO while IDLE starts on the first tick edge after the push edge.
//     A send and a tick on the same edge do not start a frame that edge.
//   fifo_count decrements on the pop edge. busy stays high throughout back-to-back frames.
//   overflow is a pulse, not sticky. tick while rst=1 is ignored.
// TESTING
//   1. DATA_BITS=8, PARITY=0, STOP_BITS=1. Push 0x0B.
//      -> tx per tick: 0,1,1,0,1,0,0,0,0,1, then idle high. Loopback uart_rx gives data_out=0x0B.
//   2. PARITY=2, push 0x0B -> parity bit 1. PARITY=1, push 0x0B -> parity bit 0.
//      STOP_BITS=2 -> tx holds 1 for two ticks.
//   3. Push 0x11,0x22,0x33,0x44 on consecutive clks (depth 4).
//      -> four frames with no idle bit between them, busy constantly 1, fifo_count 4->3 at the first pop, then down to 0.
//   4. While full (frame in flight, 4 queued), push 0x55.
//      -> overflow=1 for one clk, fifo_count stays 4, 0x55 is never transmitted.
//   5. Assert rst during DATA bit 3.
//      -> next edge: tx=1, busy=0, fifo_count=0. The following tick produces no start bit.
//   6. Push on the same edge as a tick while IDLE.
//      -> start bit appears at the next tick, not this one. fifo_count goes 0->1->0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small TX FIFO in front of it.
//   The host queues bytes with send; each byte is sent as one frame made of
//   a start bit, the data bits LSB first, an optional parity bit and one or
//   two stop bits. Bit timing comes from the shared baud tick.
// Ports:
//   clk        system clock; all logic runs on posedge
//   rst        synchronous reset, active high
//   tick       one-clock pulse per bit period
//   data_in    byte to enqueue
//   send       enqueue strobe; data_in is taken when send && !full
//   full       FIFO holds FIFO_DEPTH entries
//   overflow   one-clock pulse when send arrives while full (byte dropped)
//   fifo_count entries waiting in the FIFO (not counting the frame in flight)
//   busy       transmitter is not idle
//   tx         serial line, registered, idles high
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          send,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for a frame: odd parity inverts the XOR reduction.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~^d;
        end else begin
            return ^d;
        end
    endfunction

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full;
    logic                 r_overflow;
    logic                 r_busy;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [CW-1:0]        w_count_nxt;
    logic [DATA_BITS-1:0] w_head;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [BW-1:0]        w_bit_idx_nxt;
    logic                 w_stop_idx_nxt;
    logic                 w_par_nxt;
    logic                 w_tx_nxt;

    assign w_empty = (r_count == {CW{1'b0}});
    assign w_push  = send && !r_full;
    assign w_head  = r_mem[r_rd_ptr];

    // Next FIFO occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Frame sequencer: everything advances only on a baud tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_par_nxt      = r_par;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_par_nxt   = parity_of(w_head);
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                    end
                end
                S_START: begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = {BW{1'b0}};
                    w_tx_nxt      = r_shift[0];
                end
                S_DATA: begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_bit_idx_nxt = {BW{1'b0}};
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt    = S_STOP;
                            w_stop_idx_nxt = 1'b0;
                            w_tx_nxt       = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                        // Next bit is the one that becomes shift[0] after this shift.
                        w_tx_nxt      = r_shift[1];
                    end
                end
                S_PARITY: begin
                    w_state_nxt    = S_STOP;
                    w_stop_idx_nxt = 1'b0;
                    w_tx_nxt       = 1'b1;
                end
                S_STOP: begin
                    if (r_stop_idx == LAST_STOP) begin
                        if (!w_empty) begin
                            // Back-to-back: next start bit follows the last stop bit directly.
                            w_pop       = 1'b1;
                            w_shift_nxt = w_head;
                            w_par_nxt   = parity_of(w_head);
                            w_tx_nxt    = 1'b0;
                            w_state_nxt = S_START;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end else begin
            w_pop = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and the status flags derived from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == DEPTH_C);
            r_overflow <= send && r_full;
        end
    end

    // Transmitter state and the registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= {DATA_BITS{1'b0}};
            r_bit_idx  <= {BW{1'b0}};
            r_stop_idx <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign full       = r_full;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;
    assign busy       = r_busy;
    assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E2, 8O1) share one stimulus.
// Expected line bits are queued per instance when a byte is accepted and
// compared against tx/busy after every tick edge.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       send;
    logic [7:0] data_in;
    logic [2:0] full_s;
    logic [2:0] ovf_s;
    logic [2:0] busy_s;
    logic [2:0] tx_s;
    logic [2:0] cnt_s [3];

    int n_chk  = 0;
    int n_fail = 0;

    logic q0 [$];
    logic q1 [$];
    logic q2 [$];

    typedef struct {
        logic       snd;
        logic [7:0] d;
        logic       tk;
        logic       acc;
        logic [2:0] cnt;
        logic       fl;
        logic       ovf;
    } vec_t;
    vec_t tbl [9];

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .send(send),
        .full(full_s[0]), .overflow(ovf_s[0]), .fifo_count(cnt_s[0]),
        .busy(busy_s[0]), .tx(tx_s[0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .send(send),
        .full(full_s[1]), .overflow(ovf_s[1]), .fifo_count(cnt_s[1]),
        .busy(busy_s[1]), .tx(tx_s[1]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .send(send),
        .full(full_s[2]), .overflow(ovf_s[2]), .fifo_count(cnt_s[2]),
        .busy(busy_s[2]), .tx(tx_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, return 2 time units after the posedge.
    task automatic cyc(input logic r, input logic s, input logic [7:0] d, input logic t);
        @(negedge clk);
        rst = r; send = s; data_in = d; tick = t;
        @(posedge clk);
        #2;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
        end
    endtask

    // Append the line bits of one frame to instance k's expectation queue.
    task automatic push_frame(input int k, input logic [7:0] d, input int par, input int stops);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par == 2) bits.push_back(^d);
        else if (par == 1) bits.push_back(~^d);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            case (k)
                0:       q0.push_back(bits[i]);
                1:       q1.push_back(bits[i]);
                default: q2.push_back(bits[i]);
            endcase
        end
    endtask

    task automatic add_frame(input logic [7:0] d);
        push_frame(0, d, 0, 1);
        push_frame(1, d, 2, 2);
        push_frame(2, d, 1, 1);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] c, input logic f, input logic o);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s u%0d count", tag, k), {29'd0, cnt_s[k]}, {29'd0, c});
            chk($sformatf("%s u%0d full", tag, k), {31'd0, full_s[k]}, {31'd0, f});
            chk($sformatf("%s u%0d overflow", tag, k), {31'd0, ovf_s[k]}, {31'd0, o});
        end
    endtask

    task automatic mon_check(input int k);
        logic e_tx;
        logic e_busy;
        e_tx = 1'b1;
        e_busy = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e_tx = q0.pop_front(); e_busy = 1'b1; end
            1: if (q1.size() > 0) begin e_tx = q1.pop_front(); e_busy = 1'b1; end
            default: if (q2.size() > 0) begin e_tx = q2.pop_front(); e_busy = 1'b1; end
        endcase
        chk($sformatf("u%0d tx", k), {31'd0, tx_s[k]}, {31'd0, e_tx});
        chk($sformatf("u%0d busy", k), {31'd0, busy_s[k]}, {31'd0, e_busy});
    endtask

    // Line monitor: one expected bit per instance per tick edge.
    always @(posedge clk) begin
        if (tick) begin
            #1;
            for (int k = 0; k < 3; k++) mon_check(k);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              snd   d      tk    acc   cnt   fl    ovf
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h66, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 8'h77, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};

        rst = 1'b1; send = 1'b0; tick = 1'b0; data_in = 8'h00;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk_all("reset", 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset u%0d tx", k), {31'd0, tx_s[k]}, 32'd1);
            chk($sformatf("reset u%0d busy", k), {31'd0, busy_s[k]}, 32'd0);
        end

        // Single frame of 0x0B on all three formats.
        cyc(1'b0, 1'b1, 8'h0B, 1'b0);
        add_frame(8'h0B);
        chk_all("push0B", 3'd1, 1'b0, 1'b0);
        run_ticks(14);
        chk_all("after0B", 3'd0, 1'b0, 1'b0);

        // Burst fill, overflow and rejected push while full.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, tbl[i].snd, tbl[i].d, tbl[i].tk);
            if (tbl[i].acc) add_frame(tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fl, tbl[i].ovf);
        end
        run_ticks(70);
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);
        chk("q2 drained", q2.size(), 32'd0);
        chk_all("drained", 3'd0, 1'b0, 1'b0);

        // Reset in the middle of data bit 3, with two bytes still queued.
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        add_frame(8'h3C);
        run_ticks(5);
        cyc(1'b0, 1'b1, 8'h81, 1'b0);
        cyc(1'b0, 1'b1, 8'h42, 1'b0);
        chk_all("prereset", 3'd2, 1'b0, 1'b0);
        q0.delete(); q1.delete(); q2.delete();
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk_all("midreset", 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midreset u%0d tx", k), {31'd0, tx_s[k]}, 32'd1);
            chk($sformatf("midreset u%0d busy", k), {31'd0, busy_s[k]}, 32'd0);
        end
        cyc(1'b1, 1'b1, 8'h99, 1'b0);
        chk_all("send in reset", 3'd0, 1'b0, 1'b0);
        run_ticks(3);
        chk_all("postreset", 3'd0, 1'b0, 1'b0);

        // Push on a tick edge while idle: start bit waits for the next tick.
        cyc(1'b0, 1'b1, 8'hA5, 1'b1);
        add_frame(8'hA5);
        chk_all("push on tick", 3'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("popA5", 3'd0, 1'b0, 1'b0);
        run_ticks(14);
        chk("q0 final", q0.size(), 32'd0);
        chk("q1 final", q1.size(), 32'd0);
        chk("q2 final", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
